// File: rtl/sbox_ti_sched.sv
// rtl/sbox_ti_sched.sv - issue scheduler and credit-guarded result FIFO for a pipelined 3-share TI AES S-box
// Optional exit remasking with an extra LFSR step per exit: define SBOX_SCHED_REMASK_EN.
module sbox_ti_sched #(
    parameter int SBOX_LAT   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          seed_valid,
    input  logic [31:0]                   seed,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_sh1,
    input  logic [7:0]                    in_sh2,
    input  logic [7:0]                    in_sh3,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_sh1,
    output logic [7:0]                    out_sh2,
    output logic [7:0]                    out_sh3,
    output logic [TAG_W-1:0]              out_tag,
    output logic [7:0]                    sbox_in1,
    output logic [7:0]                    sbox_in2,
    output logic [7:0]                    sbox_in3,
    output logic [7:0]                    sbox_r0,
    output logic [7:0]                    sbox_r1,
    input  logic [7:0]                    sbox_out1,
    input  logic [7:0]                    sbox_out2,
    input  logic [7:0]                    sbox_out3,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {ST_SEED, ST_RUN, ST_DRAIN} state_t;

    state_t               state;
    logic [31:0]          lfsr, lfsr_next;
    logic                 issue_valid;
    logic [TAG_W-1:0]     issue_tag;
    logic [SBOX_LAT-1:0]  pipe_valid;
    logic [TAG_W-1:0]     pipe_tag [SBOX_LAT];
    logic [7:0]           fifo_sh1 [FIFO_DEPTH];
    logic [7:0]           fifo_sh2 [FIFO_DEPTH];
    logic [7:0]           fifo_sh3 [FIFO_DEPTH];
    logic [TAG_W-1:0]     fifo_tag [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [OCC_W-1:0]     fifo_cnt;
    logic [7:0]           push_sh1, push_sh2, push_sh3;
    logic                 accept, exit_op, pop, fifo_empty, inflight;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    assign in_ready   = (state == ST_RUN) && (occupancy < DEPTH_C);
    assign accept     = in_valid && in_ready;
    assign exit_op    = pipe_valid[SBOX_LAT-1];
    assign fifo_empty = (fifo_cnt == '0);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    // The issue register counts as in flight: the op is inside the S-box from the next cycle on.
    assign inflight   = issue_valid || (|pipe_valid);
    assign busy       = inflight || !fifo_empty;

    assign out_sh1 = fifo_empty ? 8'h00 : fifo_sh1[rd_ptr];
    assign out_sh2 = fifo_empty ? 8'h00 : fifo_sh2[rd_ptr];
    assign out_sh3 = fifo_empty ? 8'h00 : fifo_sh3[rd_ptr];
    assign out_tag = fifo_empty ? '0 : fifo_tag[rd_ptr];

    always_comb begin
        lfsr_next = lfsr;
        push_sh1  = sbox_out1;
        push_sh2  = sbox_out2;
        push_sh3  = sbox_out3;
`ifdef SBOX_SCHED_REMASK_EN
        if (accept)  lfsr_next = lfsr_step(lfsr_next);
        if (exit_op) lfsr_next = lfsr_step(lfsr_next);
        push_sh1 = sbox_out1 ^ lfsr[23:16];
        push_sh2 = sbox_out2 ^ lfsr[31:24];
        push_sh3 = sbox_out3 ^ lfsr[23:16] ^ lfsr[31:24];
`else
        if (accept)  lfsr_next = lfsr_step(lfsr);
`endif
        if (seed_valid) lfsr_next = (seed == 32'h0) ? 32'h1 : seed;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_SEED;
            lfsr        <= 32'h1;
            issue_valid <= 1'b0;
            issue_tag   <= '0;
            sbox_in1    <= 8'h00;
            sbox_in2    <= 8'h00;
            sbox_in3    <= 8'h00;
            sbox_r0     <= 8'h00;
            sbox_r1     <= 8'h00;
            pipe_valid  <= '0;
            for (int i = 0; i < SBOX_LAT; i++) pipe_tag[i] <= '0;
            occupancy   <= '0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                ST_SEED:  if (seed_valid) state <= ST_RUN;
                ST_RUN:   if (flush) state <= ST_DRAIN;
                ST_DRAIN: if (!inflight) state <= ST_RUN;
                default:  state <= ST_SEED;
            endcase
            issue_valid <= accept;
            issue_tag   <= accept ? in_tag : '0;
            sbox_in1    <= accept ? in_sh1 : 8'h00;
            sbox_in2    <= accept ? in_sh2 : 8'h00;
            sbox_in3    <= accept ? in_sh3 : 8'h00;
            sbox_r0     <= accept ? lfsr[7:0] : 8'h00;
            sbox_r1     <= accept ? lfsr[15:8] : 8'h00;
            pipe_valid  <= {pipe_valid[SBOX_LAT-2:0], issue_valid};
            pipe_tag[0] <= issue_tag;
            for (int i = 1; i < SBOX_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
            // Slots are reserved at accept, so an exiting op always has room in the FIFO.
            case ({accept, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_sh1[i] <= 8'h00;
                fifo_sh2[i] <= 8'h00;
                fifo_sh3[i] <= 8'h00;
                fifo_tag[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (exit_op) begin
                fifo_sh1[wr_ptr] <= push_sh1;
                fifo_sh2[wr_ptr] <= push_sh2;
                fifo_sh3[wr_ptr] <= push_sh3;
                fifo_tag[wr_ptr] <= pipe_tag[SBOX_LAT-1];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({exit_op, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_ti_sched.sv
// tb/tb_sbox_ti_sched.sv - bench for sbox_ti_sched with an S-box pipeline model and an op-level scoreboard
module tb_sbox_ti_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] seed;
    logic [7:0]  in_sh1, in_sh2, in_sh3, out_sh1, out_sh2, out_sh3;
    logic [3:0]  in_tag, out_tag;
    logic [7:0]  sbox_in1, sbox_in2, sbox_in3, sbox_r0, sbox_r1;
    logic [7:0]  sbox_out1, sbox_out2, sbox_out3;
    logic [2:0]  occupancy;

    sbox_ti_sched dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sh1(in_sh1), .in_sh2(in_sh2),
        .in_sh3(in_sh3), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sh1(out_sh1), .out_sh2(out_sh2), .out_sh3(out_sh3), .out_tag(out_tag),
        .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3),
        .sbox_r0(sbox_r0), .sbox_r1(sbox_r1), .sbox_out1(sbox_out1),
        .sbox_out2(sbox_out2), .sbox_out3(sbox_out3), .busy(busy), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0, pops = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // AES S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    // External 3-stage S-box: output shares carry the fresh masks, their XOR is S(x).
    logic [7:0] p1 [3], p2 [3], p3 [3];
    always @(posedge clk) begin
        p1[0] <= sbox_fn(sbox_in1 ^ sbox_in2 ^ sbox_in3) ^ sbox_r0;
        p2[0] <= sbox_r1 ^ sbox_in1;
        p3[0] <= sbox_r0 ^ sbox_r1 ^ sbox_in1;
        p1[1] <= p1[0]; p2[1] <= p2[0]; p3[1] <= p3[0];
        p1[2] <= p1[1]; p2[2] <= p2[1]; p3[2] <= p3[1];
    end
    assign sbox_out1 = p1[2];
    assign sbox_out2 = p2[2];
    assign sbox_out3 = p3[2];

    typedef struct {
        logic [7:0] e1, e2, e3;
        logic [3:0] tag;
        int         rdy;
    } op_t;
    op_t         q[$];
    op_t         nop;
    int          mstate = 0;
    logic [31:0] mlfsr = 32'h1;
    logic        prev_acc = 1'b0;
    logic [7:0]  pin1, pin2, pin3, pr0, pr1;
    logic        infl, fne, exp_ready, exp_ov, acc, mpop;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_occupancy", occupancy, 0);
            chk("rst_sbox_in", {sbox_in1, sbox_in2, sbox_in3, sbox_r0}, 0);
            chk("rst_out", {out_sh1, out_sh2, out_sh3, 4'h0, out_tag}, 0);
            q.delete();
            mstate = 0; mlfsr = 32'h1; prev_acc = 1'b0;
        end else begin
            infl = 1'b0; fne = 1'b0;
            foreach (q[i]) begin
                if (cyc >= q[i].rdy - 4 && cyc < q[i].rdy) infl = 1'b1;
                if (q[i].rdy <= cyc) fne = 1'b1;
            end
            exp_ready = (mstate == 1) && (q.size() < 4);
            exp_ov    = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("occupancy", occupancy, q.size());
            chk("busy", busy, infl || fne);
            chk("sbox_in", {sbox_in1, sbox_in2, sbox_in3}, prev_acc ? {pin1, pin2, pin3} : 24'h0);
            if (prev_acc) chk("sbox_mask", {sbox_r0, sbox_r1}, {pr0, pr1});
            if (exp_ov) begin
                chk("out_sh", {out_sh1, out_sh2, out_sh3}, {q[0].e1, q[0].e2, q[0].e3});
                chk("out_tag", out_tag, q[0].tag);
            end
            acc  = exp_ready && in_valid;
            mpop = exp_ov && out_ready;
            if (mpop) begin void'(q.pop_front()); pops++; end
            prev_acc = acc;
            if (acc) begin
                pin1 = in_sh1; pin2 = in_sh2; pin3 = in_sh3;
                pr0 = mlfsr[7:0]; pr1 = mlfsr[15:8];
                nop.e1  = sbox_fn(in_sh1 ^ in_sh2 ^ in_sh3) ^ pr0;
                nop.e2  = pr1 ^ in_sh1;
                nop.e3  = pr0 ^ pr1 ^ in_sh1;
                nop.tag = in_tag;
                nop.rdy = cyc + 5;
                q.push_back(nop);
            end
            if (seed_valid) mlfsr = (seed == 0) ? 32'h1 : seed;
            else if (acc) mlfsr = lfsr_step(mlfsr);
            case (mstate)
                0: if (seed_valid) mstate = 1;
                1: if (flush) mstate = 2;
                default: if (!infl) mstate = 1;
            endcase
        end
        cyc++;
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [3:0] t);
        bit ok = 0;
        #1 in_valid = 1'b1; in_sh1 = a; in_sh2 = b; in_sh3 = c; in_tag = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
        end
        if (!ok) chk("issue_timeout", 0, 1);
    endtask

    task automatic do_seed(input logic [31:0] v);
        #1 seed_valid = 1'b1; seed = v;
        @(posedge clk);
        #1 seed_valid = 1'b0;
    endtask

    int lat, acc_n, w, p0;
    logic [7:0] ra, rb, rc;

    initial begin
        rst = 1'b0; seed_valid = 0; seed = 0; flush = 0; in_valid = 0;
        in_sh1 = 0; in_sh2 = 0; in_sh3 = 0; in_tag = 0; out_ready = 1'b1;
        chk("model_S_00", sbox_fn(8'h00), 8'h63);
        chk("model_S_53", sbox_fn(8'h53), 8'hED);
        chk("model_S_01", sbox_fn(8'h01), 8'h7C);
        chk("model_lfsr_step", lfsr_step(32'h1), 32'h8020_0003);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        in_valid = 1'b1; in_sh1 = 8'h11; in_tag = 4'h3;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("noseed_in_ready", in_ready, 0);
        chk("noseed_out_valid", out_valid, 0);
        chk("noseed_busy", busy, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;

        do_seed(32'h0000_ACE1);
        issue(8'h53, 8'h00, 8'h00, 4'h5);
        #1 in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            @(posedge clk);
        end
        chk("first_latency", lat, 5);
        chk("first_xor", out_sh1 ^ out_sh2 ^ out_sh3, 8'hED);
        chk("first_tag", out_tag, 4'h5);
        @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            issue(ra, rb, rc, 4'(i));
        end
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);

        #1 out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            #1 in_valid = 1'b1; in_sh1 = 8'(i * 37); in_sh2 = 8'(i + 5); in_sh3 = 8'hA5; in_tag = 4'(i + 8);
            @(negedge clk);
            if (in_ready) acc_n++;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        chk("bp_accepts", acc_n, 4);
        @(negedge clk);
        chk("bp_occupancy", occupancy, 4);
        chk("bp_in_ready", in_ready, 0);
        @(posedge clk);
        p0 = pops;
        #1 out_ready = 1'b1;
        repeat (12) @(posedge clk);
        chk("bp_released", pops - p0, 4);

        #1 out_ready = 1'b0;
        issue(8'h01, 8'h02, 8'h03, 4'h1);
        issue(8'hF0, 8'h0F, 8'h33, 4'h2);
        #1 in_valid = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b1; in_sh1 = 8'h77; in_tag = 4'h9;
        w = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            @(posedge clk);
        end
        chk("drain_cycles", w, 4);
        chk("drain_fifo_occ", occupancy, 2);
        chk("drain_out_valid", out_valid, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);

        issue(8'h12, 8'h34, 8'h56, 4'hA);
        issue(8'h9A, 8'hBC, 8'hDE, 4'hB);
        #1 in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        p0 = pops;
        do_seed(32'h0);
        issue(8'hC3, 8'h00, 8'h00, 4'hC);
        #1 in_valid = 1'b0;
        repeat (12) @(posedge clk);
        chk("reseed_results", pops - p0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
